// File: rtl/time_date_counter.sv
// Real-time clock and calendar: prescaled seconds counter cascading into min/hour/day/month/year,
// with clamped load from the key controller and halt while the current time is edited.
module time_date_counter #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [5:0]  MODE,
    input  logic        SETTING,
    input  logic [17:0] SET_TIME,
    input  logic [15:0] SET_DATE,
    output logic [17:0] CUR_TIME,
    output logic [15:0] CUR_DATE,
    output logic        SEC_TICK
);

    localparam int unsigned PRESC_W = 32;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         sec_q, sec_d;
    logic [5:0]         min_q, min_d;
    logic [4:0]         hour_q, hour_d;
    logic [4:0]         day_q, day_d;
    logic [3:0]         month_q, month_d;
    logic [6:0]         year_q, year_d;
    logic               fmt_q;
    logic               setting_d_q;
    logic               sec_tick_q, sec_tick_d;

    logic               halt, load, tick;
    logic [4:0]         ld_hour, ld_day, ld_dim, cur_dim;
    logic [5:0]         ld_min, ld_sec;
    logic [3:0]         ld_month;
    logic [6:0]         ld_year;
    logic               c_min, c_hour, c_day, c_month, c_year;
    logic               unused_mode;

    assign unused_mode = ^MODE[4:1];

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [6:0] year);
        logic [4:0] dim;
        case (month)
            4'd2:                   dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            default:                dim = 5'd31;
        endcase
        return dim;
    endfunction

    assign halt = MODE[0] & ~MODE[5];
    assign load = SETTING & ~setting_d_q & ~MODE[5];
    assign tick = (presc_q == PRESC_MAX) & ~halt;

    // Clamp the requested setting; day limit uses the already-clamped month and year.
    always_comb begin
        ld_hour  = (SET_TIME[16:12] > 5'd23) ? 5'd23 : SET_TIME[16:12];
        ld_min   = (SET_TIME[11:6]  > 6'd59) ? 6'd59 : SET_TIME[11:6];
        ld_sec   = (SET_TIME[5:0]   > 6'd59) ? 6'd59 : SET_TIME[5:0];
        ld_year  = (SET_DATE[15:9]  > 7'd99) ? 7'd99 : SET_DATE[15:9];
        if (SET_DATE[8:5] == 4'd0)
            ld_month = 4'd1;
        else if (SET_DATE[8:5] > 4'd12)
            ld_month = 4'd12;
        else
            ld_month = SET_DATE[8:5];
        ld_dim = days_in_month(ld_month, ld_year);
        if (SET_DATE[4:0] == 5'd0)
            ld_day = 5'd1;
        else if (SET_DATE[4:0] > ld_dim)
            ld_day = ld_dim;
        else
            ld_day = SET_DATE[4:0];
    end

    assign cur_dim = days_in_month(month_q, year_q);
    assign c_min   = (sec_q == 6'd59);
    assign c_hour  = c_min & (min_q == 6'd59);
    assign c_day   = c_hour & (hour_q == 5'd23);
    assign c_month = c_day & (day_q == cur_dim);
    assign c_year  = c_month & (month_q == 4'd12);

    // Next-state: load beats tick; halt freezes everything.
    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        sec_tick_d = 1'b0;
        if (load) begin
            presc_d = '0;
            sec_d   = ld_sec;
            min_d   = ld_min;
            hour_d  = ld_hour;
            day_d   = ld_day;
            month_d = ld_month;
            year_d  = ld_year;
        end else if (tick) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            sec_d      = c_min ? 6'd0 : sec_q + 6'd1;
            if (c_min)
                min_d = c_hour ? 6'd0 : min_q + 6'd1;
            if (c_hour)
                hour_d = c_day ? 5'd0 : hour_q + 5'd1;
            if (c_day)
                day_d = c_month ? 5'd1 : day_q + 5'd1;
            if (c_month)
                month_d = c_year ? 4'd1 : month_q + 4'd1;
            if (c_year)
                year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
        end else if (!halt) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= '0;
            fmt_q       <= 1'b0;
            setting_d_q <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            fmt_q       <= SET_TIME[17];
            setting_d_q <= SETTING;
            sec_tick_q  <= sec_tick_d;
        end
    end

    assign CUR_TIME = {fmt_q, hour_q, min_q, sec_q};
    assign CUR_DATE = {year_q, month_q, day_q};
    assign SEC_TICK = sec_tick_q;

endmodule

// File: tb/tb_time_date_counter.sv
// Self-checking bench for time_date_counter: seconds-of-day calendar model plus directed scenarios.
module tb_time_date_counter;

    localparam int unsigned TD = 4;

    logic        CLK;
    logic        RESETN;
    logic [5:0]  MODE;
    logic        SETTING;
    logic [17:0] SET_TIME;
    logic [15:0] SET_DATE;
    logic [17:0] CUR_TIME;
    logic [15:0] CUR_DATE;
    logic        SEC_TICK;

    int checks   = 0;
    int failures = 0;

    time_date_counter #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .RESETN(RESETN), .MODE(MODE), .SETTING(SETTING),
        .SET_TIME(SET_TIME), .SET_DATE(SET_DATE),
        .CUR_TIME(CUR_TIME), .CUR_DATE(CUR_DATE), .SEC_TICK(SEC_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] pt(input int f, input int h, input int m, input int s);
        return {1'(f), 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] pd(input int y, input int mo, input int d);
        return {7'(y), 4'(mo), 5'(d)};
    endfunction

    function automatic int dim(input int mo, input int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Calendar model: time kept as seconds-of-day, date as plain integers.
    int   m_sod, m_day, m_month, m_year, m_presc;
    logic m_fmt, m_setd, m_tick;
    int   ly, lm;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_sod <= 0; m_day <= 1; m_month <= 1; m_year <= 0; m_presc <= 0;
            m_fmt <= 1'b0; m_setd <= 1'b0; m_tick <= 1'b0;
        end else begin
            m_fmt  <= SET_TIME[17];
            m_setd <= SETTING;
            m_tick <= 1'b0;
            if (SETTING && !m_setd && !MODE[5]) begin
                ly = clampi(int'(SET_DATE[15:9]), 0, 99);
                lm = clampi(int'(SET_DATE[8:5]), 1, 12);
                m_year  <= ly;
                m_month <= lm;
                m_day   <= clampi(int'(SET_DATE[4:0]), 1, dim(lm, ly));
                m_sod   <= clampi(int'(SET_TIME[16:12]), 0, 23) * 3600
                         + clampi(int'(SET_TIME[11:6]), 0, 59) * 60
                         + clampi(int'(SET_TIME[5:0]), 0, 59);
                m_presc <= 0;
            end else if (!(MODE[0] && !MODE[5])) begin
                if (m_presc == int'(TD) - 1) begin
                    m_presc <= 0;
                    m_tick  <= 1'b1;
                    if (m_sod == 86399) begin
                        m_sod <= 0;
                        if (m_day == dim(m_month, m_year)) begin
                            m_day <= 1;
                            if (m_month == 12) begin
                                m_month <= 1;
                                m_year  <= (m_year + 1) % 100;
                            end else
                                m_month <= m_month + 1;
                        end else
                            m_day <= m_day + 1;
                    end else
                        m_sod <= m_sod + 1;
                end else
                    m_presc <= m_presc + 1;
            end
        end
    end

    always @(negedge CLK) begin
        check("model_time", 32'(CUR_TIME),
              32'({m_fmt, 5'(m_sod / 3600), 6'((m_sod / 60) % 60), 6'(m_sod % 60)}));
        check("model_date", 32'(CUR_DATE), 32'(pd(m_year, m_month, m_day)));
        check("model_tick", 32'(SEC_TICK), 32'(m_tick));
    end

    task automatic tick_wait(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!SEC_TICK && n < 20);
    endtask

    task automatic do_load(input logic [5:0] mode, input logic [17:0] t, input logic [15:0] d);
        MODE = mode; SET_TIME = t; SET_DATE = d; SETTING = 1'b1;
        @(negedge CLK);
        SETTING = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n, ticks;
        RESETN = 1'b0; MODE = 6'd0; SETTING = 1'b0; SET_TIME = '0; SET_DATE = '0;
        repeat (2) @(negedge CLK);
        check("reset_time", 32'(CUR_TIME), 32'h0);
        check("reset_date", 32'(CUR_DATE), 32'h0021);
        check("reset_tick", 32'(SEC_TICK), 32'h0);
        RESETN = 1'b1;
        repeat (6) @(negedge CLK);
        check("pre_reset_sec", 32'(CUR_TIME), 32'(pt(0, 0, 0, 1)));

        // Asynchronous reset in the middle of a count
        #2 RESETN = 1'b0;
        #1;
        check("midreset_time", 32'(CUR_TIME), 32'h0);
        check("midreset_date", 32'(CUR_DATE), 32'h0021);
        check("midreset_tick", 32'(SEC_TICK), 32'h0);
        @(negedge CLK);
        RESETN = 1'b1;
        tick_wait(n);
        check("first_tick_latency", 32'(n), 32'd4);
        check("first_tick_sec", 32'(CUR_TIME), 32'(pt(0, 0, 0, 1)));

        // Full rollover
        do_load(6'd0, pt(0, 23, 59, 59), pd(99, 12, 31));
        check("rollover_loaded", 32'(CUR_DATE), 32'(pd(99, 12, 31)));
        ticks = 0;
        repeat (4) begin @(negedge CLK); if (SEC_TICK) ticks++; end
        check("rollover_time", 32'(CUR_TIME), 32'h0);
        check("rollover_date", 32'(CUR_DATE), 32'h0021);
        check("rollover_ticks", 32'(ticks), 32'd1);

        // Leap and non-leap February
        do_load(6'd0, pt(0, 23, 59, 59), pd(4, 2, 28));
        repeat (4) @(negedge CLK);
        check("leap_date", 32'(CUR_DATE), 32'(pd(4, 2, 29)));
        do_load(6'd0, pt(0, 23, 59, 59), pd(5, 2, 28));
        repeat (4) @(negedge CLK);
        check("nonleap_date", 32'(CUR_DATE), 32'(pd(5, 3, 1)));

        // Clamped load while halted, then held SETTING
        MODE = 6'b010011; SET_TIME = pt(0, 25, 61, 7); SET_DATE = pd(127, 4, 31); SETTING = 1'b1;
        @(negedge CLK);
        check("clamp_time", 32'(CUR_TIME), 32'(pt(0, 23, 59, 7)));
        check("clamp_date", 32'(CUR_DATE), 32'(pd(99, 4, 30)));
        SET_TIME = pt(0, 1, 2, 3); SET_DATE = pd(10, 10, 10);
        ticks = 0;
        repeat (20) begin @(negedge CLK); if (SEC_TICK) ticks++; end
        check("held_no_reload_time", 32'(CUR_TIME), 32'(pt(0, 23, 59, 7)));
        check("held_no_reload_date", 32'(CUR_DATE), 32'(pd(99, 4, 30)));
        SETTING = 1'b0;
        repeat (40) begin @(negedge CLK); if (SEC_TICK) ticks++; end
        check("halt_ticks", 32'(ticks), 32'd0);
        check("halt_frozen", 32'(CUR_TIME), 32'(pt(0, 23, 59, 7)));

        // Alarm mode keeps counting and ignores SETTING
        MODE = 6'b110011;
        ticks = 0;
        repeat (40) begin @(negedge CLK); if (SEC_TICK) ticks++; end
        check("alarm_ticks", 32'(ticks), 32'd10);
        check("alarm_time", 32'(CUR_TIME), 32'(pt(0, 23, 59, 17)));
        SET_TIME = pt(0, 5, 5, 5); SET_DATE = pd(50, 5, 5); SETTING = 1'b1;
        repeat (2) @(negedge CLK);
        SETTING = 1'b0;
        @(negedge CLK);
        check("alarm_noload_time", 32'(CUR_TIME), 32'(pt(0, 23, 59, 17)));
        check("alarm_noload_date", 32'(CUR_DATE), 32'(pd(99, 4, 30)));

        // Load colliding with a tick
        MODE = 6'd0;
        tick_wait(n);
        check("collision_sync_bound", 32'(n < 20), 32'd1);
        repeat (3) @(negedge CLK);
        SET_TIME = pt(1, 10, 20, 30); SET_DATE = pd(21, 6, 15); SETTING = 1'b1;
        @(negedge CLK);
        check("collision_time", 32'(CUR_TIME), 32'(pt(1, 10, 20, 30)));
        check("collision_date", 32'(CUR_DATE), 32'(pd(21, 6, 15)));
        check("collision_tick", 32'(SEC_TICK), 32'd0);
        SETTING = 1'b0;
        tick_wait(n);
        check("collision_next_tick", 32'(n), 32'd4);
        check("collision_next_time", 32'(CUR_TIME), 32'(pt(1, 10, 20, 31)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
